// File: rtl/link_refine_pkg.sv
// Shared widths, match-bit indices and helpers for the upstream link
// refinement monitor.
package link_refine_pkg;

    localparam int NUM_CH_DEF     = 2;
    localparam int CH_W_DEF       = 16;
    localparam int CNT_W_DEF      = 7;
    localparam int TOKEN_STEP_DEF = 8;
    localparam int CREDIT_MAX_DEF = 64;
    localparam int CYC_W_DEF      = 4;
    localparam int CYC_MAX_DEF    = 6;
    localparam int END_CYCLE_DEF  = 1;

    localparam int MATCH_W      = 4;
    localparam int MATCH_SENT   = 0;
    localparam int MATCH_FINISH = 1;
    localparam int MATCH_DATA   = 2;
    localparam int MATCH_VALID  = 3;

    localparam int PC_W = 32;

    function automatic int unsigned popcount(input logic [PC_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PC_W; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/link_refine_window.sv
// Instruction window tracker: start pulse, sticky started/ended flags
// and a saturating cycle counter.
module link_refine_window #(
    parameter int CYC_W     = 4,
    parameter int CYC_MAX   = 6,
    parameter int END_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    output logic             start_o,
    output logic             started_o,
    output logic             ended_o,
    output logic             ended2_o,
    output logic [CYC_W-1:0] cycle_cnt_o,
    output logic             iend_o
);

    localparam logic [CYC_W-1:0] CYC_LIM = CYC_W'(CYC_MAX);
    localparam logic [CYC_W-1:0] END_V   = CYC_W'(END_CYCLE);

    logic             start_q, start_d;
    logic             started_q, started_d;
    logic             ended_q, ended_d;
    logic             ended2_q, ended2_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             edcond;

    always_comb begin
        edcond    = started_q && (cyc_q == END_V);
        iend_o    = edcond && !ended_q;
        start_d   = issue_i && !start_q && !started_q;
        started_d = started_q | start_q;
        cyc_d     = cyc_q;
        if ((start_q || started_q) && (cyc_q < CYC_LIM)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
        ended_d  = ended_q | iend_o;
        ended2_d = ended2_q | (ended_q && edcond && !ended2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            started_q <= 1'b0;
            ended_q   <= 1'b0;
            ended2_q  <= 1'b0;
            cyc_q     <= '0;
        end else begin
            start_q   <= start_d;
            started_q <= started_d;
            ended_q   <= ended_d;
            ended2_q  <= ended2_d;
            cyc_q     <= cyc_d;
        end
    end

    assign start_o     = start_q;
    assign started_o   = started_q;
    assign ended_o     = ended_q;
    assign ended2_o    = ended2_q;
    assign cycle_cnt_o = cyc_q;

endmodule

// File: rtl/link_upstream_refine_monitor.sv
// Refinement monitor shadowing an N-channel upstream link and checking
// it against ILA spec values at instruction end.
module link_upstream_refine_monitor
    import link_refine_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CH_W       = CH_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TOKEN_STEP = TOKEN_STEP_DEF,
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CYC_W      = CYC_W_DEF,
    parameter int CYC_MAX    = CYC_MAX_DEF,
    parameter int END_CYCLE  = END_CYCLE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic [NUM_CH-1:0]      ch_valid_i,
    input  logic [NUM_CH-1:0]      ch_ready_i,
    input  logic [NUM_CH*CH_W-1:0] ch_data_i,
    input  logic                   commit_mark_i,
    input  logic                   token_toggle_i,
    input  logic [CNT_W-1:0]       spec_sent_i,
    input  logic [CNT_W-1:0]       spec_finish_i,
    input  logic [NUM_CH*CH_W-1:0] spec_data_i,
    input  logic                   spec_valid_i,
    output logic                   start_o,
    output logic                   started_o,
    output logic                   ended_o,
    output logic                   ended2_o,
    output logic [CYC_W-1:0]       cycle_cnt_o,
    output logic [CNT_W-1:0]       sent_cnt_o,
    output logic [CNT_W-1:0]       finish_cnt_o,
    output logic [NUM_CH*CH_W-1:0] data_o,
    output logic                   data_valid_o,
    output logic                   commit_o,
    output logic [MATCH_W-1:0]     match_o,
    output logic                   mismatch_o,
    output logic                   credit_ovf_o
);

    localparam int DW = NUM_CH * CH_W;
    localparam logic [CNT_W-1:0] STEP_V = CNT_W'(TOKEN_STEP);

    logic iend;

    link_refine_window #(
        .CYC_W     (CYC_W),
        .CYC_MAX   (CYC_MAX),
        .END_CYCLE (END_CYCLE)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue_i),
        .start_o     (start_o),
        .started_o   (started_o),
        .ended_o     (ended_o),
        .ended2_o    (ended2_o),
        .cycle_cnt_o (cycle_cnt_o),
        .iend_o      (iend)
    );

    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [CNT_W-1:0]  finish_q, finish_d;
    logic              tok_q;
    logic [DW-1:0]     data_q, data_d;
    logic              dval_q, dval_d;
    logic              commit_q, commit_d;
    logic              mis_q, mis_d;
    logic              ovf_q, ovf_d;
    logic [NUM_CH-1:0] hs;
    logic [CNT_W-1:0]  outstanding;

    always_comb begin
        match_o               = '0;
        match_o[MATCH_SENT]   = (sent_q == spec_sent_i);
        match_o[MATCH_FINISH] = (finish_q == spec_finish_i);
        match_o[MATCH_DATA]   = (data_q == spec_data_i);
        match_o[MATCH_VALID]  = (ch_valid_i[0] == spec_valid_i);
    end

    always_comb begin
        hs          = ch_valid_i & ch_ready_i;
        sent_d      = sent_q + CNT_W'(popcount(PC_W'(hs)));
        finish_d    = finish_q;
        if (token_toggle_i != tok_q) begin
            finish_d = finish_q + STEP_V;
        end
        // Outstanding wraps with the counters, so a token ahead of the
        // beats shows up as a large positive value.
        outstanding = sent_q - finish_q;
        ovf_d       = ovf_q | (32'(outstanding) > 32'(CREDIT_MAX));
        data_d      = data_q;
        dval_d      = dval_q;
        if (&ch_valid_i) begin
            data_d = ch_data_i;
            dval_d = 1'b1;
        end
        commit_d = commit_q;
        if (commit_mark_i && ch_ready_i[0]) begin
            commit_d = 1'b1;
        end else if (commit_q && ch_ready_i[0]) begin
            commit_d = 1'b0;
        end
        mis_d = mis_q | (iend && !(&match_o));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q   <= '0;
            finish_q <= '0;
            tok_q    <= 1'b0;
            data_q   <= '0;
            dval_q   <= 1'b0;
            commit_q <= 1'b0;
            mis_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sent_q   <= sent_d;
            finish_q <= finish_d;
            tok_q    <= token_toggle_i;
            data_q   <= data_d;
            dval_q   <= dval_d;
            commit_q <= commit_d;
            mis_q    <= mis_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sent_cnt_o   = sent_q;
    assign finish_cnt_o = finish_q;
    assign data_o       = data_q;
    assign data_valid_o = dval_q;
    assign commit_o     = commit_q;
    assign mismatch_o   = mis_q;
    assign credit_ovf_o = ovf_q;

endmodule
